// File: rtl/iomem_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_initiator
//  Description : Second-requester initiator for the iomem peripheral bus.
//                Turns one word-access command into 1..256 iomem beats with a
//                4-byte address stride. Returns one response per beat with the
//                captured read data and a timeout error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module iomem_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        ck,
  input  logic        resetn,
  // command stream
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic [7:0]  cmd_count,
  // response stream
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic        busy,
  // iomem bus
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } state_t;

  // Timer value seen during the last permitted valid cycle of a beat.
  localparam logic [15:0] c_TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;

  logic        w_accept;
  logic        w_beat_done;
  logic        w_timeout;
  logic        w_rsp_hs;

  logic        r_cmd_ready;
  logic        r_busy;
  logic        r_valid;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [7:0]  r_remaining;
  logic [15:0] r_timer;

  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic        r_rsp_last;

  // State register.
  always_ff @(posedge ck) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and the per-cycle events the datapath reacts to.
  // Ready is checked before the timeout so a ready on the final cycle wins.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_beat_done  = 1'b0;
    w_timeout    = 1'b0;
    w_rsp_hs     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = BUS;
        end
      end
      BUS: begin
        if (iomem_ready) begin
          w_beat_done  = 1'b1;
          w_state_next = RSP;
        end else if (r_timer == c_TIMER_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          w_rsp_hs     = 1'b1;
          w_state_next = r_rsp_last ? IDLE : BUS;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Request side: latched command, beat address, remaining count, valid and
  // the per-beat valid-cycle timer.
  always_ff @(posedge ck) begin
    if (!resetn) begin
      r_valid     <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_remaining <= 8'd0;
      r_timer     <= 16'd0;
    end else begin
      if (w_accept) begin
        r_valid     <= 1'b1;
        r_addr      <= cmd_addr & 32'hFFFF_FFFC;
        r_wdata     <= cmd_wdata;
        r_wstrb     <= cmd_wstrb;
        r_remaining <= cmd_count;
        r_timer     <= 16'd0;
      end else if (w_beat_done || w_timeout) begin
        r_valid <= 1'b0;
      end else if (r_state == BUS) begin
        r_timer <= r_timer + 16'd1;
      end else if (w_rsp_hs && !r_rsp_last) begin
        // Advance to the next beat; the address wraps naturally at 32 bits.
        r_valid     <= 1'b1;
        r_addr      <= r_addr + 32'd4;
        r_remaining <= r_remaining - 8'd1;
        r_timer     <= 16'd0;
      end
    end
  end

  // Response side: capture on completion or timeout, hold until handshake.
  always_ff @(posedge ck) begin
    if (!resetn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      if (w_beat_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= iomem_rdata;
        r_rsp_err   <= 1'b0;
        r_rsp_last  <= (r_remaining == 8'd0);
      end else if (w_timeout) begin
        // A timed-out beat ends the command; remaining beats are dropped.
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= 32'd0;
        r_rsp_err   <= 1'b1;
        r_rsp_last  <= 1'b1;
      end else if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Command-side flags: busy spans acceptance to the final response handshake.
  always_ff @(posedge ck) begin
    if (!resetn) begin
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      if (w_accept) begin
        r_busy      <= 1'b1;
        r_cmd_ready <= 1'b0;
      end else if (w_rsp_hs && r_rsp_last) begin
        r_busy      <= 1'b0;
        r_cmd_ready <= 1'b1;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign iomem_valid = r_valid;
  assign iomem_addr  = r_addr;
  assign iomem_wdata = r_wdata;
  assign iomem_wstrb = r_wstrb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign rsp_last    = r_rsp_last;

endmodule
`default_nettype wire

// File: tb/tb_iomem_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iomem_initiator
//  Description : Self-checking bench for iomem_initiator: directed vector
//                table, hand-written timeout/reset sequences and randomized
//                commands checked against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_initiator;

  localparam int TO = 8;

  logic        ck = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic [3:0]  cmd_wstrb = 4'd0;
  logic [7:0]  cmd_count = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_last;
  logic        busy;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata = 32'd0;

  iomem_initiator #(.TIMEOUT(TO)) dut (
    .ck(ck), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_count(cmd_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
  );

  always #5 ck = ~ck;

  typedef struct packed {logic [31:0] d; logic e; logic l;} rsp_t;
  typedef struct packed {logic [31:0] a; logic [31:0] wd; logic [3:0] ws;} beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  count;
    int          lat;
    bit          en;
    int          mode;
    int          exp_n;
    logic        exp_err;
    logic [31:0] exp_d0;
    logic [31:0] exp_alast;
    int          exp_cyc;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // environment controls (written by the main sequence only)
  int resp_lat = 1;
  bit resp_en = 1'b1;
  int rsp_mode = 0;
  bit man_rdy = 1'b1;
  int late_req = 0;

  // observations (written by the monitor only)
  rsp_t  obs_rsp[$];
  beat_t obs_beat[$];
  int    obs_runs[$];
  int    n_overlap = 0;
  int    n_rdybusy = 0;
  int    n_unstable = 0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h0300_0000) ? 32'h0000_00A5 : ((a ^ 32'h5EED_0000) + 32'h11);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Responder: ready after resp_lat+1 valid cycles, or an injected stray pulse.
  int vcnt = 0;
  int late_seen = 0;
  always @(posedge ck) begin
    logic [31:0] a;
    logic [31:0] old;
    #1;
    if (late_req != late_seen) begin
      late_seen   = late_req;
      iomem_ready = 1'b1;
      iomem_rdata = 32'hDEAD_BEEF;
      vcnt        = 0;
    end else if (!resetn || !iomem_valid || iomem_ready) begin
      iomem_ready = 1'b0;
      vcnt        = 0;
    end else begin
      vcnt = vcnt + 1;
      if (resp_en && vcnt == resp_lat + 1) begin
        a           = iomem_addr;
        old         = dev_mem.exists(a) ? dev_mem[a] : dflt(a);
        iomem_rdata = old;
        iomem_ready = 1'b1;
        if (iomem_wstrb != 4'd0) dev_mem[a] = merge(old, iomem_wdata, iomem_wstrb);
      end else begin
        iomem_ready = 1'b0;
      end
    end
  end

  // Response consumer back-pressure.
  always @(posedge ck) begin
    #1;
    case (rsp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = !rsp_ready;
      2:       rsp_ready = ($urandom_range(0, 1) == 1);
      default: rsp_ready = man_rdy;
    endcase
  end

  // Monitor: records handshakes and valid bursts, counts protocol violations.
  int          run_len = 0;
  bit          hold_prev = 1'b0;
  logic [33:0] prev_rsp = '0;
  always @(negedge ck) begin
    if (iomem_valid && iomem_ready) obs_beat.push_back({iomem_addr, iomem_wdata, iomem_wstrb});
    if (rsp_valid && rsp_ready) obs_rsp.push_back({rsp_data, rsp_err, rsp_last});
    if (iomem_valid) run_len = run_len + 1;
    else if (run_len != 0) begin
      obs_runs.push_back(run_len);
      run_len = 0;
    end
    if (iomem_valid && rsp_valid) n_overlap = n_overlap + 1;
    if (cmd_ready && busy) n_rdybusy = n_rdybusy + 1;
    if (resetn && hold_prev && (!rsp_valid || {rsp_data, rsp_err, rsp_last} != prev_rsp))
      n_unstable = n_unstable + 1;
    hold_prev = resetn && rsp_valid && !rsp_ready;
    prev_rsp  = {rsp_data, rsp_err, rsp_last};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_iomem_valid"}, 32'(iomem_valid), 32'd0);
    chk({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    chk({tag, "_rsp_err"},     32'(rsp_err),     32'd0);
    chk({tag, "_rsp_last"},    32'(rsp_last),    32'd0);
    chk({tag, "_rsp_data"},    rsp_data,         32'd0);
    chk({tag, "_busy"},        32'(busy),        32'd0);
    chk({tag, "_iomem_addr"},  iomem_addr,       32'd0);
    chk({tag, "_iomem_wdata"}, iomem_wdata,      32'd0);
    chk({tag, "_iomem_wstrb"}, 32'(iomem_wstrb), 32'd0);
    chk({tag, "_cmd_ready"},   32'(cmd_ready),   32'd1);
  endtask

  // Offer a command and hold it until accepted; returns at edge+1 after acceptance.
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic [7:0] cnt, output bit ok);
    @(posedge ck); #1;
    cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws; cmd_count = cnt; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ck);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge ck); #1;
    end
    @(posedge ck); #1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom); cmd_count = 8'($urandom);
    chk("cmd_accept", 32'(ok), 32'd1);
  endtask

  // Run one command and compare everything observed against the model.
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input logic [7:0] cnt, input int lat, input bit en, input int mode,
                         output int cyc, output int b_r, output int b_b);
    rsp_t        exp_r[$];
    beat_t       exp_b[$];
    int          exp_v[$];
    logic [31:0] wa;
    logic [31:0] old;
    bit          ok;
    int          b_v;
    wa = {a[31:2], 2'b00};
    if (en && lat < TO) begin
      for (int i = 0; i <= int'(cnt); i++) begin
        old = ref_rd(wa);
        exp_r.push_back({old, 1'b0, (i == int'(cnt))});
        exp_b.push_back({wa, wd, ws});
        exp_v.push_back(lat + 1);
        if (ws != 4'd0) ref_mem[wa] = merge(old, wd, ws);
        wa = wa + 32'd4;
      end
    end else begin
      exp_r.push_back({32'd0, 1'b1, 1'b1});
      exp_v.push_back(TO);
    end
    @(negedge ck);
    resp_lat = lat; resp_en = en; rsp_mode = mode;
    b_r = obs_rsp.size(); b_b = obs_beat.size(); b_v = obs_runs.size();
    send_cmd(a, wd, ws, cnt, ok);
    cyc = 0;
    if (ok) begin
      for (cyc = 0; cyc < 3000; cyc++) begin
        @(negedge ck);
        if (cmd_ready) break;
        @(posedge ck);
      end
      chk("cmd_done", 32'(cmd_ready), 32'd1);
    end
    chk("rsp_count", obs_rsp.size() - b_r, exp_r.size());
    for (int i = 0; i < exp_r.size(); i++) begin
      if (b_r + i < obs_rsp.size()) begin
        chk($sformatf("rsp_data[%0d]", i), obs_rsp[b_r + i].d, exp_r[i].d);
        chk($sformatf("rsp_err[%0d]", i),  32'(obs_rsp[b_r + i].e), 32'(exp_r[i].e));
        chk($sformatf("rsp_last[%0d]", i), 32'(obs_rsp[b_r + i].l), 32'(exp_r[i].l));
      end
    end
    chk("beat_count", obs_beat.size() - b_b, exp_b.size());
    for (int i = 0; i < exp_b.size(); i++) begin
      if (b_b + i < obs_beat.size()) begin
        chk($sformatf("beat_addr[%0d]", i),  obs_beat[b_b + i].a, exp_b[i].a);
        chk($sformatf("beat_wdata[%0d]", i), obs_beat[b_b + i].wd, exp_b[i].wd);
        chk($sformatf("beat_wstrb[%0d]", i), 32'(obs_beat[b_b + i].ws), 32'(exp_b[i].ws));
      end
    end
    chk("valid_runs", obs_runs.size() - b_v, exp_v.size());
    for (int i = 0; i < exp_v.size(); i++) begin
      if (b_v + i < obs_runs.size())
        chk($sformatf("valid_len[%0d]", i), obs_runs[b_v + i], exp_v[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt[8];
    int          cyc, br, bb, bv;
    bit          ok, found;
    logic [31:0] d0, alast;
    logic [31:0] ra;
    logic [3:0]  rws;

    //        addr          wdata         wstrb cnt  lat en mode n err d0                   alast         cyc
    vt[0] = '{32'h0300_0000, 32'h0,        4'h0, 8'd0, 1, 1, 0, 1, 0, 32'h0000_00A5,      32'h0300_0000, 3};
    vt[1] = '{32'h0300_0000, 32'h0000_003C, 4'h1, 8'd0, 1, 1, 0, 1, 0, 32'h0000_00A5,      32'h0300_0000, 3};
    vt[2] = '{32'h0300_0003, 32'h0,        4'h0, 8'd0, 1, 1, 0, 1, 0, 32'h0000_003C,      32'h0300_0000, 3};
    vt[3] = '{32'h0300_00F8, 32'h0,        4'h0, 8'd3, 1, 1, 1, 4, 0, dflt(32'h0300_00F8), 32'h0300_0104, 0};
    vt[4] = '{32'h0300_1000, 32'h0,        4'h0, 8'd2, 1, 0, 0, 1, 1, 32'h0,              32'h0,         9};
    vt[5] = '{32'h0300_2000, 32'h0,        4'h0, 8'd0, 7, 1, 0, 1, 0, dflt(32'h0300_2000), 32'h0300_2000, 9};
    vt[6] = '{32'hFFFF_FFF8, 32'h1234_5678, 4'hF, 8'd3, 0, 1, 0, 4, 0, dflt(32'hFFFF_FFF8), 32'h0000_0004, 8};
    vt[7] = '{32'hFFFF_FFF8, 32'h0,        4'h0, 8'd1, 1, 1, 2, 2, 0, 32'h1234_5678,      32'hFFFF_FFFC, 0};

    // reset state
    repeat (3) @(posedge ck);
    @(negedge ck);
    chk_reset_outputs("por");
    resetn = 1'b1;
    @(negedge ck);
    chk("por_cmd_ready_after", 32'(cmd_ready), 32'd1);

    // directed vectors
    for (int t = 0; t < 8; t++) begin
      run_cmd(vt[t].addr, vt[t].wdata, vt[t].wstrb, vt[t].count, vt[t].lat, vt[t].en,
              vt[t].mode, cyc, br, bb);
      chk($sformatf("v%0d_nrsp", t), obs_rsp.size() - br, vt[t].exp_n);
      d0 = (obs_rsp.size() > br) ? obs_rsp[br].d : 32'hFFFF_FFFF;
      chk($sformatf("v%0d_data0", t), d0, vt[t].exp_d0);
      chk($sformatf("v%0d_err0", t),
          (obs_rsp.size() > br) ? 32'(obs_rsp[br].e) : 32'hFFFF_FFFF, 32'(vt[t].exp_err));
      if (!vt[t].exp_err) begin
        alast = (obs_beat.size() > bb) ? obs_beat[obs_beat.size() - 1].a : 32'hFFFF_FFFF;
        chk($sformatf("v%0d_last_addr", t), alast, vt[t].exp_alast);
      end
      if (vt[t].exp_cyc != 0) chk($sformatf("v%0d_cmd_ready_lat", t), cyc, vt[t].exp_cyc);
    end

    // timeout held in RSP, then a stray late ready
    @(negedge ck);
    resp_en = 1'b0; resp_lat = 0; rsp_mode = 3; man_rdy = 1'b0;
    br = obs_rsp.size(); bb = obs_beat.size(); bv = obs_runs.size();
    send_cmd(32'h0300_3000, 32'h0, 4'h0, 8'd2, ok);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ck);
      if (rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("to_rsp_seen", 32'(found), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_data", rsp_data, 32'd0);
    chk("to_rsp_last", 32'(rsp_last), 32'd1);
    repeat (3) @(negedge ck);
    late_req = late_req + 1;
    repeat (3) @(negedge ck);
    chk("late_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("late_rsp_data", rsp_data, 32'd0);
    chk("late_rsp_err", 32'(rsp_err), 32'd1);
    chk("late_iomem_valid", 32'(iomem_valid), 32'd0);
    chk("to_valid_runs", obs_runs.size() - bv, 1);
    if (obs_runs.size() > bv) chk("to_valid_len", obs_runs[bv], TO);
    man_rdy = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ck);
      if (cmd_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk("to_done", 32'(found), 32'd1);
    repeat (4) @(negedge ck);
    chk("to_rsp_count", obs_rsp.size() - br, 1);
    chk("to_beat_count", obs_beat.size() - bb, 0);
    chk("to_runs_after", obs_runs.size() - bv, 1);

    // reset during beat 2 of 4
    @(negedge ck);
    resp_lat = 3; resp_en = 1'b1; rsp_mode = 0;
    br = obs_rsp.size(); bb = obs_beat.size();
    send_cmd(32'h0300_4000, 32'hAAAA_5555, 4'h0, 8'd3, ok);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ck);
      if (obs_beat.size() == bb + 1 && iomem_valid && !iomem_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_reach_beat2", 32'(found), 32'd1);
    resetn = 1'b0;
    @(negedge ck);
    chk_reset_outputs("rst_mid");
    @(negedge ck);
    resetn = 1'b1;
    repeat (8) @(negedge ck);
    chk("rst_rsp_count", obs_rsp.size() - br, 1);
    chk("rst_beat_count", obs_beat.size() - bb, 1);
    chk("rst_idle_valid", 32'(iomem_valid), 32'd0);
    chk("rst_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    run_cmd(32'h0300_5004, 32'h0, 4'h0, 8'd1, 1, 1'b1, 0, cyc, br, bb);
    chk("rst_new_addr", (obs_beat.size() > bb) ? obs_beat[bb].a : 32'hFFFF_FFFF, 32'h0300_5004);

    // randomized commands against the model
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFE0 + 32'($urandom_range(0, 7) * 4);
      else ra = 32'h0300_0000 + 32'($urandom_range(0, 63) * 4);
      ra  = ra | 32'($urandom_range(0, 3));
      rws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_cmd(ra, $urandom, rws, 8'($urandom_range(0, 5)), $urandom_range(0, 9),
              ($urandom_range(0, 9) != 0), $urandom_range(0, 2), cyc, br, bb);
    end

    // protocol invariants over the whole run
    chk("no_valid_with_rsp_valid", n_overlap, 0);
    chk("no_cmd_ready_while_busy", n_rdybusy, 0);
    chk("rsp_stable_under_backpressure", n_unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
